ssd_scan_decoder: RTL



---
 rtl/ssd_scan_decoder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ssd_scan_decoder.sv
// ssd_scan_decoder: receive-side decoder for a multiplexed, active-low
// seven-segment display bus. It waits for each digit's pattern to be stable,
// decodes it to a hex nibble and assembles full frames. Frames are presented
// on a valid/ready port.
// Optional feature: define SSD_SCAN_DEC_DP_EN to also sample the decimal
// point (dp_in) and present it per digit on dp_out.
module ssd_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     an_in,
`ifdef SSD_SCAN_DEC_DP_EN
  input  logic                  dp_in,
  output logic [DIGITS-1:0]     dp_out,
`endif
  output logic [4*DIGITS-1:0]   value_out,
  output logic                  err_out,
  output logic                  overrun_out,
  output logic                  valid_out,
  input  logic                  ready_in
);

`ifdef SSD_SCAN_DEC_DP_EN
  localparam int DPW = 1;
`else
  localparam int DPW = 0;
`endif
  localparam int SW    = DIGITS + 7 + DPW;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {BLANK, SETTLE, LOCKED} state_t;

  // Active-low pattern to {error, nibble}; unknown patterns give nibble 0.
  function automatic logic [4:0] dec7(input logic [6:0] p);
    case (p)
      7'h40: dec7 = 5'h00;  7'h79: dec7 = 5'h01;
      7'h24: dec7 = 5'h02;  7'h30: dec7 = 5'h03;
      7'h19: dec7 = 5'h04;  7'h12: dec7 = 5'h05;
      7'h02: dec7 = 5'h06;  7'h78: dec7 = 5'h07;
      7'h00: dec7 = 5'h08;  7'h10: dec7 = 5'h09;
      7'h08: dec7 = 5'h0A;  7'h03: dec7 = 5'h0B;
      7'h46: dec7 = 5'h0C;  7'h21: dec7 = 5'h0D;
      7'h06: dec7 = 5'h0E;  7'h0E: dec7 = 5'h0F;
      default: dec7 = 5'h10;
    endcase
  endfunction

  logic [SW-1:0]        smp_d, smp_q, prv_q;
  state_t               state_q;
  logic [7:0]           cnt_q;
  logic [DIGITS-1:0]    seen_q;
  logic [3:0]           slot_nib_q [DIGITS];
  logic [DIGITS-1:0]    slot_err_q;
  logic [4*DIGITS-1:0]  slot_flat;
  logic [4*DIGITS-1:0]  value_q;
  logic                 err_q, ovr_q, valid_q;
  logic [DIGITS-1:0]    anl;
  logic [IDX_W-1:0]     dig;
  logic                 onehot;
  logic [4:0]           dec;
  logic                 frame_done;
  int                   ones;
`ifdef SSD_SCAN_DEC_DP_EN
  logic [DIGITS-1:0]    slot_dp_q;
  logic [DIGITS-1:0]    dp_q;
  assign smp_d  = {dp_in, an_in, seg_in};
  assign dp_out = dp_q;
`else
  assign smp_d  = {an_in, seg_in};
`endif

  assign dec         = dec7(smp_q[6:0]);
  assign frame_done  = &seen_q;
  assign value_out   = value_q;
  assign err_out     = err_q;
  assign overrun_out = ovr_q;
  assign valid_out   = valid_q;

  // Find which anode is low in the registered sample and whether it is unique.
  always_comb begin
    anl    = ~smp_q[7 +: DIGITS];
    ones   = 0;
    dig    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (anl[i]) begin
        ones = ones + 1;
        dig  = IDX_W'(i);
      end
    end
    onehot = (ones == 1);
  end

  // Flatten the slot nibbles into frame order.
  always_comb begin
    slot_flat = '0;
    for (int i = 0; i < DIGITS; i++) slot_flat[4*i +: 4] = slot_nib_q[i];
  end

  // Register the raw bus every cycle; idle value is "no anode, all segments off".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) smp_q <= '1;
    else     smp_q <= smp_d;
  end

  // Capture FSM: count equal samples of a one-hot digit, then write its slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BLANK;
      cnt_q      <= '0;
      seen_q     <= '0;
      prv_q      <= '1;
      slot_err_q <= '0;
      for (int i = 0; i < DIGITS; i++) slot_nib_q[i] <= '0;
`ifdef SSD_SCAN_DEC_DP_EN
      slot_dp_q  <= '0;
`endif
    end else begin
      prv_q <= smp_q;
      if (frame_done) seen_q <= '0;
      if (smp_q != prv_q) begin
        state_q <= onehot ? SETTLE : BLANK;
        cnt_q   <= onehot ? 8'd1 : 8'd0;
      end else if (state_q == SETTLE) begin
        if (cnt_q == CNT_LAST) begin
          slot_nib_q[dig] <= dec[3:0];
          slot_err_q[dig] <= dec[4];
`ifdef SSD_SCAN_DEC_DP_EN
          slot_dp_q[dig]  <= ~smp_q[SW-1];
`endif
          seen_q[dig]     <= 1'b1;
          state_q         <= LOCKED;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
    end
  end

  // Output port: load completed frames, track overrun, retire on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      valid_q <= 1'b0;
`ifdef SSD_SCAN_DEC_DP_EN
      dp_q    <= '0;
`endif
    end else if (frame_done) begin
      value_q <= slot_flat;
      err_q   <= |slot_err_q;
      valid_q <= 1'b1;
`ifdef SSD_SCAN_DEC_DP_EN
      dp_q    <= slot_dp_q;
`endif
      if (valid_q && !ready_in) ovr_q <= 1'b1;
    end else if (valid_q && ready_in) begin
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end
  end

endmodule
